// File: rtl/neuron_acc_pkg.sv
// Shared types and helpers for the neuron accumulator: FSM states, internal sum
// width and the output saturation function.
package neuron_acc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    BIAS,
    OUT
  } state_t;

  // Saturation works on a wide signed value so one function serves every width.
  localparam int SAT_CALC_W = 64;

  typedef struct packed {
    logic signed [SAT_CALC_W-1:0] val;
    logic                         flag;
  } sat_res_t;

  // Wide enough that LEN full-scale products plus the bias can never wrap.
  function automatic int sum_width(input int din_w, input int bias_w, input int len);
    return ((din_w > bias_w) ? din_w : bias_w) + $clog2(len) + 1;
  endfunction

  function automatic sat_res_t saturate(input logic signed [SAT_CALC_W-1:0] v,
                                        input int acc_w);
    logic signed [SAT_CALC_W-1:0] hi;
    logic signed [SAT_CALC_W-1:0] lo;
    sat_res_t                     r;
    hi     = (64'sd1 <<< (acc_w - 1)) - 64'sd1;
    lo     = -(64'sd1 <<< (acc_w - 1));
    r.val  = v;
    r.flag = 1'b0;
    if (v > hi) begin
      r.val  = hi;
      r.flag = 1'b1;
    end else if (v < lo) begin
      r.val  = lo;
      r.flag = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/neuron_acc_if.sv
// Beat input / result output handshake bundle of the neuron accumulator.
// The producer and consumer side (testbench or datapath) use the master modport.
interface neuron_acc_if #(
  parameter int DIN_W  = 20,
  parameter int BIAS_W = 8,
  parameter int ACC_W  = 22,
  parameter int N_CH   = 4
);

  logic                     in_valid;
  logic                     in_ready;
  logic [N_CH*DIN_W-1:0]    din;
  logic [N_CH*BIAS_W-1:0]   bias;
  logic                     out_valid;
  logic                     out_ready;
  logic [N_CH*ACC_W-1:0]    dout;
  logic [N_CH-1:0]          sat;

  modport master (
    output in_valid, din, bias, out_ready,
    input  in_ready, out_valid, dout, sat
  );

  modport slave (
    input  in_valid, din, bias, out_ready,
    output in_ready, out_valid, dout, sat
  );

endinterface

// File: rtl/neuron_acc_lane.sv
// One neuron channel: running sum, latched bias, final bias add, saturation and
// optional ReLU (RELU_EN). Control strobes come from the shared FSM in neuron_acc.
module acc_lane
  import neuron_acc_pkg::*;
#(
  parameter int DIN_W  = 20,
  parameter int BIAS_W = 8,
  parameter int ACC_W  = 22,
  parameter int SUM_W  = 31
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load,
  input  logic                     add,
  input  logic                     finish,
  input  logic signed [DIN_W-1:0]  din,
  input  logic signed [BIAS_W-1:0] bias,
  output logic signed [ACC_W-1:0]  dout,
  output logic                     sat
);

  logic signed [SUM_W-1:0]  sum;
  logic signed [BIAS_W-1:0] bias_q;
  logic signed [SUM_W:0]    total;
  sat_res_t                 res;
  logic signed [ACC_W-1:0]  clipped;
  logic signed [ACC_W-1:0]  result;

  // The flag reflects the clip before ReLU, so a clamped negative still reports.
  always_comb begin
    total   = (SUM_W + 1)'(sum) + (SUM_W + 1)'(bias_q);
    res     = saturate(SAT_CALC_W'(total), ACC_W);
    clipped = ACC_W'(res.val);
    result  = clipped;
`ifdef RELU_EN
    if (clipped[ACC_W-1]) begin
      result = '0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum    <= '0;
      bias_q <= '0;
      dout   <= '0;
      sat    <= 1'b0;
    end else begin
      if (load) begin
        sum    <= SUM_W'(din);
        bias_q <= bias;
      end else if (add) begin
        sum <= sum + SUM_W'(din);
      end
      if (finish) begin
        dout <= result;
        sat  <= res.flag;
      end
    end
  end

endmodule

// File: rtl/neuron_acc.sv
// N_CH-channel neuron accumulator: LEN-beat signed dot-product sums plus bias,
// saturated to ACC_W bits, behind valid/ready. Optional ReLU via RELU_EN.
module neuron_acc
  import neuron_acc_pkg::*;
#(
  parameter int DIN_W  = 20,
  parameter int BIAS_W = 8,
  parameter int ACC_W  = 22,
  parameter int N_CH   = 4,
  parameter int LEN    = 784
) (
  input logic         clk,
  input logic         rst,
  neuron_acc_if.slave bus
);

  localparam int SUM_W = sum_width(DIN_W, BIAS_W, LEN);
  localparam int CNT_W = $clog2(LEN + 1);

  state_t                 state;
  logic [CNT_W-1:0]       count;
  logic                   out_valid_q;
  logic                   beat;
  logic                   load;
  logic                   add;
  logic                   finish;
  logic [N_CH*ACC_W-1:0]  dout_all;
  logic [N_CH-1:0]        sat_all;

  // in_ready depends only on state and rst so no path runs from in_valid/out_ready.
  assign bus.in_ready  = !rst && ((state == IDLE) || (state == ACCUM));
  assign beat          = bus.in_valid && bus.in_ready;
  assign load          = beat && (state == IDLE);
  assign add           = beat && (state == ACCUM);
  assign finish        = (state == BIAS);
  assign bus.out_valid = out_valid_q;
  assign bus.dout      = dout_all;
  assign bus.sat       = sat_all;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      count       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (beat) begin
            count <= CNT_W'(1);
            state <= (LEN == 1) ? BIAS : ACCUM;
          end
        end
        ACCUM: begin
          if (beat) begin
            count <= count + CNT_W'(1);
            if (count == CNT_W'(LEN - 1)) begin
              state <= BIAS;
            end
          end
        end
        BIAS: begin
          out_valid_q <= 1'b1;
          state       <= OUT;
        end
        OUT: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            count       <= '0;
            state       <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  for (genvar c = 0; c < N_CH; c++) begin : g_lane
    acc_lane #(
      .DIN_W  (DIN_W),
      .BIAS_W (BIAS_W),
      .ACC_W  (ACC_W),
      .SUM_W  (SUM_W)
    ) u_lane (
      .clk    (clk),
      .rst    (rst),
      .load   (load),
      .add    (add),
      .finish (finish),
      .din    (bus.din[c*DIN_W +: DIN_W]),
      .bias   (bus.bias[c*BIAS_W +: BIAS_W]),
      .dout   (dout_all[c*ACC_W +: ACC_W]),
      .sat    (sat_all[c])
    );
  end

endmodule
